// File: rtl/fp_add_sub.sv
// Paired-single binary32 add/subtract with one-cycle latency.
// Each lane emits an unrounded, normalized 36-bit result {sign, exp, sig24, G, R, S}.
module fp_add_sub (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        sel,
   input  logic [63:0] dina,
   input  logic [63:0] dinb,
   output logic        out_valid,
   output logic [71:0] dout
);

   localparam int unsigned LANES = 2;
   localparam int unsigned IN_W  = 32;
   localparam int unsigned RES_W = 36;
   localparam int unsigned SIG_W = 27;
   localparam logic [RES_W-1:0] QNAN = {1'b0, 8'hFF, 24'h400000, 3'b000};

   // Leading-zero count of a 27-bit working significand.
   function automatic logic [4:0] lzc27(input logic [SIG_W-1:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd0;
      found = 1'b0;
      for (int i = SIG_W - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + 5'd1;
         end
      end
      return n;
   endfunction

   function automatic logic [RES_W-1:0] lane_op(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic        sub);
      logic             a_s, b_s, a_ge, big_s, lost;
      logic [7:0]       a_e, b_e, big_e, small_e, diff;
      logic [22:0]      a_f, b_f, big_f, small_f;
      logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [SIG_W-1:0] big_m, small_m, small_sh, mant;
      logic [SIG_W:0]   sum;
      logic [9:0]       e;
      logic [4:0]       lz;
      logic [RES_W-1:0] r;

      a_s = a[31];
      a_e = a[30:23];
      a_f = a[22:0];
      b_s = b[31] ^ sub;
      b_e = b[30:23];
      b_f = b[22:0];
      a_nan  = (a_e == 8'hFF) && (a_f != 23'd0);
      b_nan  = (b_e == 8'hFF) && (b_f != 23'd0);
      a_inf  = (a_e == 8'hFF) && (a_f == 23'd0);
      b_inf  = (b_e == 8'hFF) && (b_f == 23'd0);
      a_zero = (a_e == 8'd0);
      b_zero = (b_e == 8'd0);

      a_ge     = {a_e, a_f} >= {b_e, b_f};
      big_s    = a_ge ? a_s : b_s;
      big_e    = a_ge ? a_e : b_e;
      big_f    = a_ge ? a_f : b_f;
      small_e  = a_ge ? b_e : a_e;
      small_f  = a_ge ? b_f : a_f;
      big_m    = {1'b1, big_f, 3'b000};
      small_m  = {1'b1, small_f, 3'b000};
      diff     = big_e - small_e;
      lost     = 1'b0;
      small_sh = 27'd1;
      sum      = '0;
      mant     = '0;
      lz       = '0;
      e        = {2'b00, big_e};
      r        = '0;

      // Align the smaller operand; everything shifted past bit 0 collapses into sticky.
      if (diff < 8'd27) begin
         small_sh    = small_m >> diff;
         lost        = |(small_m & ~(27'h7FFFFFF << diff));
         small_sh[0] = small_sh[0] | lost;
      end

      if (a_s == b_s) sum = {1'b0, big_m} + {1'b0, small_sh};
      else            sum = {1'b0, big_m} - {1'b0, small_sh};

      if (a_nan || b_nan) begin
         r = QNAN;
      end else if (a_inf && b_inf) begin
         r = (a_s == b_s) ? {a_s, 8'hFF, 27'd0} : QNAN;
      end else if (a_inf) begin
         r = {a_s, 8'hFF, 27'd0};
      end else if (b_inf) begin
         r = {b_s, 8'hFF, 27'd0};
      end else if (a_zero && b_zero) begin
         r = {a_s & b_s, 35'd0};
      end else if (a_zero) begin
         r = {b_s, b_e, 1'b1, b_f, 3'b000};
      end else if (b_zero) begin
         r = {a_s, a_e, 1'b1, a_f, 3'b000};
      end else if (sum != '0) begin
         if (sum[SIG_W]) begin
            mant = {sum[SIG_W:2], sum[1] | sum[0]};
            e    = e + 10'd1;
         end else begin
            lz   = lzc27(sum[SIG_W-1:0]);
            mant = sum[SIG_W-1:0] << lz;
            e    = e - 10'(lz);
         end
         // Bit 9 set means the exponent went negative during normalization.
         if (e[9] || (e == 10'd0)) r = {big_s, 8'd0, 26'd0, 1'b1};
         else if (e >= 10'd255)     r = {big_s, 8'hFF, 27'd0};
         else                       r = {big_s, e[7:0], mant};
      end
      return r;
   endfunction

   logic [RES_W-1:0] lane_res [LANES];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_res[i] = lane_op(dina[i*IN_W +: IN_W], dinb[i*IN_W +: IN_W], sel);
   end

   // Output register; dout holds when no operation is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) dout <= {lane_res[1], lane_res[0]};
      end
   end

endmodule

// File: tb/tb_fp_add_sub.sv
// Scoreboard bench for fp_add_sub: expected lane results queued at drive time, checked one cycle later.
module tb_fp_add_sub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        sel = 1'b0;
   logic [63:0] dina = '0;
   logic [63:0] dinb = '0;
   logic        out_valid;
   logic [71:0] dout;

   int n_checks = 0;
   int n_fail   = 0;
   logic [71:0] exp_q[$];

   typedef struct {
      string       name;
      logic        sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [35:0] r;
   } vec_t;

   fp_add_sub dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .sel      (sel),
      .dina     (dina),
      .dinb     (dinb),
      .out_valid(out_valid),
      .dout     (dout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [71:0] expv);
      dina     = a;
      dinb     = b;
      sel      = s;
      in_valid = 1'b1;
      exp_q.push_back(expv);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || dout !== 72'h0) begin
         n_fail++;
         $display("FAIL reset_hold: got valid=%b dout=%h, want valid=0 dout=0", out_valid, dout);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || dout !== 72'h0) begin
         n_fail++;
         $display("FAIL reset_release: got valid=%b dout=%h, want valid=0 dout=0", out_valid, dout);
      end
   endtask

   task automatic test_arith;
      vec_t v[10];
      logic [71:0] expv;
      v = '{
         '{"add_1_1",      1'b0, 32'h3F800000, 32'h3F800000, 36'h404000000},
         '{"sub_3_1",      1'b1, 32'h40400000, 32'h3F800000, 36'h404000000},
         '{"sub_1_1",      1'b1, 32'h3F800000, 32'h3F800000, 36'h000000000},
         '{"sticky_far",   1'b0, 32'h3F800000, 32'h30800000, 36'h3FC000001},
         '{"add_1p5_0p25", 1'b0, 32'h3FC00000, 32'h3E800000, 36'h3FF000000},
         '{"sub_1_3",      1'b1, 32'h3F800000, 32'h40400000, 36'hC04000000},
         '{"add_neg",      1'b0, 32'hBF800000, 32'hBF800000, 36'hC04000000},
         '{"add_1_max",    1'b0, 32'h3F800000, 32'h7F7FFFFF, 36'h7F7FFFFF9},
         '{"max_max_ovf",  1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 36'h7F8000000},
         '{"underflow",    1'b1, 32'h00800001, 32'h00800000, 36'h000000001}
      };
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive({32'h0, v[i].a}, {32'h0, v[i].b}, v[i].sel, {36'h0, v[i].r});
         @(negedge clk);
         in_valid = 1'b0;
         expv = '1;
         if (exp_q.size() != 0) expv = exp_q.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || dout !== expv) begin
            n_fail++;
            $display("FAIL %s: got valid=%b dout=%h, want valid=1 dout=%h",
                     v[i].name, out_valid, dout, expv);
         end
      end
   endtask

   task automatic test_specials;
      vec_t v[7];
      logic [71:0] expv;
      v = '{
         '{"inf_minus_inf", 1'b1, 32'h7F800000, 32'h7F800000, 36'h7FA000000},
         '{"nan_a",         1'b0, 32'h7FC00000, 32'h3F800000, 36'h7FA000000},
         '{"nan_b",         1'b1, 32'h3F800000, 32'h7F800001, 36'h7FA000000},
         '{"inf_plus_1",    1'b0, 32'h7F800000, 32'h3F800000, 36'h7F8000000},
         '{"one_minus_inf", 1'b1, 32'h3F800000, 32'h7F800000, 36'hFF8000000},
         '{"ninf_ninf",     1'b0, 32'hFF800000, 32'hFF800000, 36'hFF8000000},
         '{"inf_inf",       1'b0, 32'h7F800000, 32'h7F800000, 36'h7F8000000}
      };
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive({32'h0, v[i].a}, {32'h0, v[i].b}, v[i].sel, {36'h0, v[i].r});
         @(negedge clk);
         in_valid = 1'b0;
         expv = '1;
         if (exp_q.size() != 0) expv = exp_q.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || dout !== expv) begin
            n_fail++;
            $display("FAIL %s: got valid=%b dout=%h, want valid=1 dout=%h",
                     v[i].name, out_valid, dout, expv);
         end
      end
   endtask

   task automatic test_zeros;
      vec_t v[7];
      logic [71:0] expv;
      v = '{
         '{"zero_zero",     1'b0, 32'h00000000, 32'h00000000, 36'h000000000},
         '{"nzero_sub_z",   1'b1, 32'h80000000, 32'h00000000, 36'h800000000},
         '{"nzero_add_z",   1'b0, 32'h80000000, 32'h00000000, 36'h000000000},
         '{"one_plus_z",    1'b0, 32'h3F800000, 32'h00000000, 36'h3FC000000},
         '{"z_minus_one",   1'b1, 32'h00000000, 32'h3F800000, 36'hBFC000000},
         '{"one_plus_sub",  1'b0, 32'h3F800000, 32'h00000001, 36'h3FC000000},
         '{"nsub_plus_z",   1'b0, 32'h80000005, 32'h00000000, 36'h000000000}
      };
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive({32'h0, v[i].a}, {32'h0, v[i].b}, v[i].sel, {36'h0, v[i].r});
         @(negedge clk);
         in_valid = 1'b0;
         expv = '1;
         if (exp_q.size() != 0) expv = exp_q.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || dout !== expv) begin
            n_fail++;
            $display("FAIL %s: got valid=%b dout=%h, want valid=1 dout=%h",
                     v[i].name, out_valid, dout, expv);
         end
      end
   endtask

   task automatic test_paired;
      logic [71:0] expv;
      @(negedge clk);
      drive(64'h7F7FFFFF_3F800000, 64'h3F800000_3F800000, 1'b0,
            {36'h7F7FFFFF9, 36'h404000000});
      @(negedge clk);
      drive(64'h7F7FFFFF_BF800000, 64'h7F7FFFFF_3F800000, 1'b0,
            {36'h7F8000000, 36'h000000000});
      expv = '1;
      if (exp_q.size() != 0) expv = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || dout !== expv) begin
         n_fail++;
         $display("FAIL paired_1_max: got valid=%b dout=%h, want valid=1 dout=%h", out_valid, dout, expv);
      end
      @(negedge clk);
      drive(64'h40400000_3FC00000, 64'h3F800000_3E800000, 1'b1,
            {36'h404000000, 36'h3FD000000});
      expv = '1;
      if (exp_q.size() != 0) expv = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || dout !== expv) begin
         n_fail++;
         $display("FAIL paired_max_max: got valid=%b dout=%h, want valid=1 dout=%h", out_valid, dout, expv);
      end
      @(negedge clk);
      in_valid = 1'b0;
      expv = '1;
      if (exp_q.size() != 0) expv = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || dout !== expv) begin
         n_fail++;
         $display("FAIL paired_sub: got valid=%b dout=%h, want valid=1 dout=%h", out_valid, dout, expv);
      end
   endtask

   task automatic test_back_to_back;
      vec_t v[5];
      logic [71:0] expv;
      logic [71:0] last;
      v = '{
         '{"b2b_add_1_1", 1'b0, 32'h3F800000, 32'h3F800000, 36'h404000000},
         '{"b2b_sticky",  1'b0, 32'h3F800000, 32'h30800000, 36'h3FC000001},
         '{"b2b_nan",     1'b0, 32'h7FC00000, 32'h00000000, 36'h7FA000000},
         '{"b2b_1p75",    1'b0, 32'h3FC00000, 32'h3E800000, 36'h3FF000000},
         '{"b2b_neg2",    1'b1, 32'h3F800000, 32'h40400000, 36'hC04000000}
      };
      last = '0;
      @(negedge clk);
      drive({v[0].a, v[0].a}, {v[0].b, v[0].b}, v[0].sel, {v[0].r, v[0].r});
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         expv = '1;
         if (exp_q.size() != 0) expv = exp_q.pop_front();
         last = expv;
         n_checks++;
         if (out_valid !== 1'b1 || dout !== expv) begin
            n_fail++;
            $display("FAIL %s: got valid=%b dout=%h, want valid=1 dout=%h",
                     v[i-1].name, out_valid, dout, expv);
         end
         if (i < 5) drive({v[i].a, v[i].a}, {v[i].b, v[i].b}, v[i].sel, {v[i].r, v[i].r});
         else       in_valid = 1'b0;
      end
      dina = 64'h3F800000_3F800000;
      dinb = 64'h3F800000_3F800000;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || dout !== last) begin
            n_fail++;
            $display("FAIL hold_idle: got valid=%b dout=%h, want valid=0 dout=%h", out_valid, dout, last);
         end
      end
   endtask

   task automatic test_reset_mid_op;
      @(negedge clk);
      dina     = 64'h0_3F800000;
      dinb     = 64'h0_3F800000;
      sel      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      n_checks++;
      if (out_valid !== 1'b1 || dout !== {36'h0, 36'h404000000}) begin
         n_fail++;
         $display("FAIL pre_reset_result: got valid=%b dout=%h, want valid=1 dout=%h",
                  out_valid, dout, {36'h0, 36'h404000000});
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || dout !== 72'h0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b dout=%h, want valid=0 dout=0", out_valid, dout);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || dout !== 72'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got valid=%b dout=%h, want valid=0 dout=0", out_valid, dout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_specials();
      test_zeros();
      test_paired();
      test_back_to_back();
      test_reset_mid_op();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_add_sub.md
Name: fp_add_sub

Overview:
- Registered paired-single IEEE-754 binary32 adder/subtractor for the FPU EX stage.
- Two independent 32-bit lanes are computed every cycle.
- Each lane produces an unrounded, normalized 36-bit result carrying guard/round/sticky bits; the downstream round stage rounds these and flags overflow, underflow and inexact.
- Used for ADD.S, SUB.S and ADD.PS/SUB.PS. Lane 0 is the only meaningful lane for .S operations.

Parameters:
- None. Widths are fixed: 2 lanes, binary32 inputs, 36-bit lane results.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid this cycle.
- sel  input  1  0 = add (a+b), 1 = subtract (a-b); applies to both lanes.
- dina  input  64  lane1 = [63:32], lane0 = [31:0]; binary32 operand a.
- dinb  input  64  same layout; operand b.
- out_valid  output  1  dout holds the result of the operation accepted the previous cycle.
- dout  output  72  lane1 = [71:36], lane0 = [35:0].

Behaviour:
- Lane result format (36 bits):
  - [35] sign.
  - [34:27] biased exponent.
  - [26:3] 24-bit significand, bit 26 = integer bit.
  - [2] guard, [1] round, [0] sticky.
- Lanes are fully independent; identical logic is instantiated twice.
- Latency is 1 cycle:
  - Inputs sampled at edge N appear on dout at edge N; out_valid = in_valid delayed by one cycle.
  - When in_valid=0, dout holds its previous value.
- Reset: while rst=1, dout=0 and out_valid=0 immediately (asynchronous). An operation in flight when reset asserts is discarded.
- Input classes:
  - exp=0 is treated as zero; subnormals are flushed to zero, sign kept.
  - exp=255 with frac=0 is infinity.
  - exp=255 with frac≠0 is NaN.
- Effective operation: b's sign is inverted when sel=1.
- Algorithm for finite nonzero operands:
  - Order so that |A|≥|B| (compare exponent, then fraction).
  - Result sign = sign of the larger operand.
  - Extend both significands to 27 bits as {1,frac,000}.
  - Right-shift B by the exponent difference; all shifted-out bits OR into sticky. A difference ≥27 leaves B = 0 with sticky=1.
  - Add or subtract the magnitudes in 28 bits.
  - On carry-out: shift right 1, OR the lost bit into sticky, exponent+1.
  - On subtraction: normalize left by the leading-zero count until bit26=1, exponent reduced accordingly, zeros shifted in.
- Exact zero result (equal magnitudes cancelling): all 36 bits 0 (+0).
- Both operands zero: result is zero with sign = sign(a) AND effective sign(b); all other bits 0.
- One operand zero: the result is the other operand in lane format with G/R/S=0.
- Exponent overflow (normalized exponent ≥255): exp=FF, significand/G/R/S=0, sign kept (infinity pattern).
- Exponent underflow (normalized exponent ≤0): exp=0, significand=0, G=R=0, sticky=1, sign kept.
- Special operands:
  - Inf ± finite = that Inf.
  - Inf + Inf of the same effective sign = Inf.
  - Inf − Inf (opposite effective signs) = canonical qNaN: sign 0, exp FF, [26:3]=24'h400000, G/R/S=0.
  - Any NaN input gives the same canonical qNaN.
- No flags are output; rounding and exception detection are done downstream from dout.

Test Plan:
- 1.0+1.0 lane0: dina=0x3F800000, dinb=0x3F800000, sel=0, in_valid=1 → next cycle out_valid=1, dout[35:0]=0x404000000.
- 3.0−1.0 lane0: dina=0x40400000, dinb=0x3F800000, sel=1 → dout[35:0]=0x404000000. 1.0−1.0 → dout[35:0]=0.
- Sticky path: 1.0+2^-30 (0x3F800000, 0x30800000), sel=0 → dout[35:0]=0x3FC000001.
- Paired lanes: dina=0x3F800000_3F800000, dinb=0x7F7FFFFF_3F800000, sel=0 → lane0 (1.0+1.0)=0x404000000; lane1 (1.0+max float) = exp FE, G=R=0, sticky=1 (not overflow). Separately, max+max (0x7F7FFFFF+0x7F7FFFFF) → lane result 0x7F8000000.
- Specials: Inf−Inf (0x7F800000, 0x7F800000, sel=1) → 0x7FA000000. Any NaN input → 0x7FA000000. Inf+1.0 → 0x7F8000000.
- Reset mid-operation: assert rst between the sampling edge and the output cycle → dout=0 and out_valid=0 immediately. After release with in_valid=0, both stay 0.
